alu_exception_unit: RTL and testbench

//   Consumes the 8-bit ALU_status word ({zero, overflow, carry, negative, invalid_address,
//   div_zero, 2'b00}) at ALU-result commit. Keeps sticky condition flags, raises exceptions
//   (overflow, misaligned load/store, divide-by-zero) toward the control unit and captures
//   EPC/cause. Holds each exception until the control unit acknowledges it (req/ack).

---
 rtl/alu_exception_unit.sv | 130 +++++++++++++
 tb/tb_alu_exception_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exception_unit.sv
// ALU exception unit: turns committed ALU status words into trap requests for the control unit.
// It also captures EPC and cause, keeps sticky condition flags and counts raised exceptions.
module alu_exception_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           ALU_status,
  input  logic                 status_valid,
  input  logic                 chk_overflow,
  input  logic                 chk_load,
  input  logic                 chk_store,
  input  logic                 chk_div,
  input  logic [PC_WIDTH-1:0]  PC_in,
  input  logic                 flags_clr,
  input  logic                 exc_ack,
  output logic                 exc_req,
  output logic [3:0]           exc_cause,
  output logic [PC_WIDTH-1:0]  EPC,
  output logic [5:0]           sticky_flags,
  output logic [CNT_WIDTH-1:0] exc_count
);

  localparam logic [3:0] CAUSE_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_STORE = 4'd5;
  localparam logic [3:0] CAUSE_OVF   = 4'd12;
  localparam logic [3:0] CAUSE_DIV   = 4'd15;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_take;
  logic                  w_trig;
  logic [3:0]            w_cause;
  logic                  w_flag_v;
  logic                  w_flag_a;
  logic                  w_flag_d;
  logic [3:0]            r_exc_cause;
  logic [PC_WIDTH-1:0]   r_epc;
  logic [5:0]            r_sticky;
  logic [CNT_WIDTH-1:0]  r_exc_count;

  assign w_flag_v = ALU_status[6];
  assign w_flag_a = ALU_status[3];
  assign w_flag_d = ALU_status[2];

  // Fixed priority: divide-by-zero, load, store, overflow.
  always_comb begin
    w_trig  = 1'b0;
    w_cause = 4'd0;
    if (w_flag_d && chk_div) begin
      w_trig  = 1'b1;
      w_cause = CAUSE_DIV;
    end else if (w_flag_a && chk_load) begin
      w_trig  = 1'b1;
      w_cause = CAUSE_LOAD;
    end else if (w_flag_a && chk_store) begin
      w_trig  = 1'b1;
      w_cause = CAUSE_STORE;
    end else if (w_flag_v && chk_overflow) begin
      w_trig  = 1'b1;
      w_cause = CAUSE_OVF;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (status_valid && w_trig) begin
          w_state_next = ST_PENDING;
          w_take       = 1'b1;
        end
      end
      ST_PENDING: begin
        // Status arriving alongside the ack is dropped, not trapped.
        if (exc_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_exc_cause <= 4'd0;
      r_epc       <= '0;
      r_exc_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_exc_cause <= w_cause;
        r_epc       <= PC_in;
        if (r_exc_count != {CNT_WIDTH{1'b1}}) begin
          r_exc_count <= r_exc_count + 1'b1;
        end
      end
    end
  end

  // Flags are frozen while an exception is outstanding; clear takes effect before the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 6'd0;
    end else if (r_state == ST_IDLE) begin
      if (flags_clr && status_valid) begin
        r_sticky <= ALU_status[7:2];
      end else if (flags_clr) begin
        r_sticky <= 6'd0;
      end else if (status_valid) begin
        r_sticky <= r_sticky | ALU_status[7:2];
      end
    end
  end

  assign exc_req      = (r_state == ST_PENDING);
  assign exc_cause    = r_exc_cause;
  assign EPC          = r_epc;
  assign sticky_flags = r_sticky;
  assign exc_count    = r_exc_count;

endmodule

// File: tb/tb_alu_exception_unit.sv
// Directed bench for alu_exception_unit: a default-width instance plus a 2-bit counter instance
// driven by the same stimulus, checked with immediate assertions.
module tb_alu_exception_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  ALU_status;
  logic        status_valid;
  logic        chk_overflow;
  logic        chk_load;
  logic        chk_store;
  logic        chk_div;
  logic [31:0] PC_in;
  logic        flags_clr;
  logic        exc_ack;

  logic        exc_req,   s_exc_req;
  logic [3:0]  exc_cause, s_exc_cause;
  logic [31:0] EPC,       s_EPC;
  logic [5:0]  sticky_flags, s_sticky_flags;
  logic [15:0] exc_count;
  logic [1:0]  s_exc_count;

  int n_asserts = 0;
  int n_fail    = 0;

  alu_exception_unit #(.PC_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .ALU_status(ALU_status), .status_valid(status_valid),
    .chk_overflow(chk_overflow), .chk_load(chk_load), .chk_store(chk_store), .chk_div(chk_div),
    .PC_in(PC_in), .flags_clr(flags_clr), .exc_ack(exc_ack),
    .exc_req(exc_req), .exc_cause(exc_cause), .EPC(EPC),
    .sticky_flags(sticky_flags), .exc_count(exc_count)
  );

  alu_exception_unit #(.PC_WIDTH(32), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst(rst), .ALU_status(ALU_status), .status_valid(status_valid),
    .chk_overflow(chk_overflow), .chk_load(chk_load), .chk_store(chk_store), .chk_div(chk_div),
    .PC_in(PC_in), .flags_clr(flags_clr), .exc_ack(exc_ack),
    .exc_req(s_exc_req), .exc_cause(s_exc_cause), .EPC(s_EPC),
    .sticky_flags(s_sticky_flags), .exc_count(s_exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ALU_status   = 8'h00;
    status_valid = 1'b0;
    chk_overflow = 1'b0;
    chk_load     = 1'b0;
    chk_store    = 1'b0;
    chk_div      = 1'b0;
    PC_in        = 32'h0;
    flags_clr    = 1'b0;
    exc_ack      = 1'b0;
  endtask

  // Apply current inputs for one rising edge, then return the inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic commit(input logic [7:0] st, input logic [3:0] chk, input logic [31:0] pc);
    ALU_status   = st;
    status_valid = 1'b1;
    chk_div      = chk[3];
    chk_load     = chk[2];
    chk_store    = chk[1];
    chk_overflow = chk[0];
    PC_in        = pc;
    tick();
  endtask

  task automatic ack();
    exc_ack = 1'b1;
    tick();
  endtask

  task automatic check_state(input string tag, input logic req, input logic [3:0] cause,
                             input logic [31:0] epc, input logic [5:0] sticky,
                             input logic [15:0] cnt, input logic [1:0] scnt);
    check({tag, ".req"},    {31'b0, exc_req}, {31'b0, req});
    check({tag, ".cause"},  {28'b0, exc_cause}, {28'b0, cause});
    check({tag, ".epc"},    EPC, epc);
    check({tag, ".sticky"}, {26'b0, sticky_flags}, {26'b0, sticky});
    check({tag, ".count"},  {16'b0, exc_count}, {16'b0, cnt});
    check({tag, ".scount"}, {30'b0, s_exc_count}, {30'b0, scnt});
    $display("step %-12s req=%0d cause=%0d epc=%08h sticky=%02h count=%0d scount=%0d",
             tag, exc_req, exc_cause, EPC, sticky_flags, exc_count, s_exc_count);
  endtask

  // chk encoding: {div, load, store, overflow}
  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_state("reset", 1'b0, 4'd0, 32'h0, 6'h00, 16'd0, 2'd0);

    // Signed overflow trap
    commit(8'h40, 4'b0001, 32'h0040_0010);
    check_state("ovf_trap", 1'b1, 4'd12, 32'h0040_0010, 6'h10, 16'd1, 2'd1);

    // Pending: new trapping commits are ignored, flags frozen
    for (int i = 0; i < 3; i++) begin
      commit(8'h0C, 4'b1000, 32'h0000_1234 + 32'(i));
      check_state("pend_hold", 1'b1, 4'd12, 32'h0040_0010, 6'h10, 16'd1, 2'd1);
    end
    ack();
    check_state("ack1", 1'b0, 4'd12, 32'h0040_0010, 6'h10, 16'd1, 2'd1);

    // Divide-by-zero beats load on A+D
    flags_clr = 1'b1;
    tick();
    check_state("clr0", 1'b0, 4'd12, 32'h0040_0010, 6'h00, 16'd1, 2'd1);
    commit(8'h0C, 4'b1100, 32'h0040_0020);
    check_state("div_prio", 1'b1, 4'd15, 32'h0040_0020, 6'h03, 16'd2, 2'd2);
    ack();
    check_state("ack2", 1'b0, 4'd15, 32'h0040_0020, 6'h03, 16'd2, 2'd2);
    commit(8'h0C, 4'b0001, 32'h0040_0024);
    check_state("no_trap", 1'b0, 4'd15, 32'h0040_0020, 6'h03, 16'd2, 2'd2);

    // Sticky accumulation and clear
    flags_clr = 1'b1;
    tick();
    commit(8'h80, 4'b0000, 32'h0);
    check_state("sticky_z", 1'b0, 4'd15, 32'h0040_0020, 6'h20, 16'd2, 2'd2);
    commit(8'h10, 4'b0000, 32'h0);
    check_state("sticky_zn", 1'b0, 4'd15, 32'h0040_0020, 6'h24, 16'd2, 2'd2);
    flags_clr = 1'b1;
    commit(8'h20, 4'b0000, 32'h0);
    check_state("clr_valid", 1'b0, 4'd15, 32'h0040_0020, 6'h08, 16'd2, 2'd2);
    flags_clr = 1'b1;
    tick();
    check_state("clr_alone", 1'b0, 4'd15, 32'h0040_0020, 6'h00, 16'd2, 2'd2);

    // Misaligned store, then load with both load/store checks (load wins)
    commit(8'h08, 4'b0010, 32'h0040_0030);
    check_state("store_trap", 1'b1, 4'd5, 32'h0040_0030, 6'h02, 16'd3, 2'd3);
    ack();
    commit(8'h08, 4'b0110, 32'h0040_0034);
    check_state("load_trap", 1'b1, 4'd4, 32'h0040_0034, 6'h02, 16'd4, 2'd3);

    // Ack together with a trapping status: ack taken, status dropped
    exc_ack = 1'b1;
    commit(8'h44, 4'b0001, 32'h0040_0038);
    check_state("ack_drop", 1'b0, 4'd4, 32'h0040_0034, 6'h02, 16'd4, 2'd3);
    tick();
    check_state("ack_drop2", 1'b0, 4'd4, 32'h0040_0034, 6'h02, 16'd4, 2'd3);

    // Back-to-back round: 2-bit counter stays saturated
    commit(8'h40, 4'b0001, 32'h0040_0040);
    check_state("sat5", 1'b1, 4'd12, 32'h0040_0040, 6'h12, 16'd5, 2'd3);
    ack();
    commit(8'h40, 4'b0001, 32'h0040_0044);
    check_state("sat6", 1'b1, 4'd12, 32'h0040_0044, 6'h12, 16'd6, 2'd3);

    // Reset while pending, then a stray ack in idle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_state("rst_pend", 1'b0, 4'd0, 32'h0, 6'h00, 16'd0, 2'd0);
    ack();
    check_state("stray_ack", 1'b0, 4'd0, 32'h0, 6'h00, 16'd0, 2'd0);
    check("sat.req", {31'b0, s_exc_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
